zjh_hc161_seq: RTL and testbench

//   Upstream run controller for the zjh_74HC161 4-bit counter. Drives its PE (active-low load), D, Cep
//   and Cet, and watches its Q and TC. Builds a modulo-(16-preset) divider that runs a programmed

---
 rtl/zjh_hc161_pkg.sv | 14 +
 rtl/zjh_74HC161.sv | 30 +++
 rtl/zjh_hc161_pass_ctr.sv | 32 +++
 rtl/zjh_hc161_seq.sv | 128 ++++++++++++
 tb/tb_zjh_hc161_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zjh_hc161_pkg.sv
// Shared types and constants for the zjh_74HC161 run controller and its counter model.
package zjh_hc161_pkg;

    localparam int         PASS_W_DEF = 8;
    localparam logic [3:0] HC161_MAX  = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/zjh_74HC161.sv
// Behavioural model of the 74HC161 4-bit synchronous counter (MR active-low clear, PE active-low load).
module zjh_74HC161
    import zjh_hc161_pkg::*;
(
    input  logic       Clk,
    input  logic       MR,
    input  logic       PE,
    input  logic [3:0] D,
    input  logic       Cep,
    input  logic       Cet,
    output logic [3:0] Q,
    output logic       TC
);

    logic [3:0] q_reg;

    always_ff @(posedge Clk) begin
        if (!MR) begin
            q_reg <= 4'h0;
        end else if (!PE) begin
            q_reg <= D;
        end else if (Cep && Cet) begin
            q_reg <= q_reg + 4'h1;
        end
    end

    assign Q  = q_reg;
    assign TC = (q_reg == HC161_MAX) && Cet;

endmodule

// File: rtl/zjh_hc161_pass_ctr.sv
// Pass counter for the run controller: counts terminal-count passes and flags the final one.
module zjh_hc161_pass_ctr #(
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clr,
    input  logic              inc,
    input  logic [PASS_W-1:0] limit,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              last_pass
);

    logic [PASS_W-1:0] pass_cnt_reg;
    logic              at_limit;

    assign at_limit  = (pass_cnt_reg == limit);
    assign last_pass = ((pass_cnt_reg + PASS_W'(1)) == limit);
    assign pass_cnt  = pass_cnt_reg;

    // Saturate at the programmed limit so the count can never run past the request.
    always_ff @(posedge clk) begin
        if (srst) begin
            pass_cnt_reg <= '0;
        end else if (clr) begin
            pass_cnt_reg <= '0;
        end else if (inc && !at_limit) begin
            pass_cnt_reg <= pass_cnt_reg + PASS_W'(1);
        end
    end

endmodule

// File: rtl/zjh_hc161_seq.sv
// Run controller for a zjh_74HC161: modulo-(16-preset) divider over a programmed number of passes.
// Optional macro ZJH_SEQ_PAUSE_EN adds a pause input that suspends counting in COUNT.
module zjh_hc161_seq
    import zjh_hc161_pkg::*;
#(
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              Clk,
    input  logic              MR,
    input  logic              start,
    input  logic [3:0]        preset,
    input  logic [PASS_W-1:0] passes,
`ifdef ZJH_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [3:0]        q_in,
    input  logic              tc_in,
    output logic              pe_n,
    output logic [3:0]        d_out,
    output logic              cep,
    output logic              cet,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    seq_state_t        state_reg, state_next;
    logic [3:0]        preset_reg;
    logic [PASS_W-1:0] passes_reg;
    logic              err_reg;
    logic              first_reg;
    logic              pause_eff;
    logic              accept;
    logic              count_en;
    logic              tc_evt;
    logic              last_pass;

`ifdef ZJH_SEQ_PAUSE_EN
    assign pause_eff = pause;
`else
    assign pause_eff = 1'b0;
`endif

    assign accept   = (state_reg == IDLE) && start;
    assign count_en = (state_reg == COUNT) && !pause_eff;
    // A TC held through a pause stays asserted, so it is counted on the first unpaused cycle.
    assign tc_evt   = count_en && tc_in;

    zjh_hc161_pass_ctr #(
        .PASS_W (PASS_W)
    ) u_pass_ctr (
        .clk       (Clk),
        .srst      (MR),
        .clr       (accept),
        .inc       (tc_evt),
        .limit     (passes_reg),
        .pass_cnt  (pass_cnt),
        .last_pass (last_pass)
    );

    always_comb begin
        state_next = state_reg;
        pe_n       = 1'b1;
        d_out      = 4'h0;
        cep        = 1'b0;
        cet        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (passes == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                pe_n       = 1'b0;
                d_out      = preset_reg;
                busy       = 1'b1;
                state_next = COUNT;
            end
            COUNT: begin
                busy  = 1'b1;
                cet   = 1'b1;
                d_out = preset_reg;
                cep   = !pause_eff;
                // Reload on TC instead of wrapping to 0; this is the only tc_in->output path.
                pe_n  = pause_eff ? 1'b1 : ~tc_in;
                if (tc_evt && last_pass) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (MR) begin
            state_reg  <= IDLE;
            preset_reg <= 4'h0;
            passes_reg <= '0;
            err_reg    <= 1'b0;
            first_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                preset_reg <= preset;
                passes_reg <= passes;
                err_reg    <= 1'b0;
            end
            if (state_reg == LOAD) begin
                first_reg <= 1'b1;
            end else if (state_reg == COUNT) begin
                first_reg <= 1'b0;
                if (first_reg && (q_in != preset_reg)) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_zjh_hc161_seq.sv
// Directed bench: run controller driving a zjh_74HC161 model, hand-computed expectations.
module tb_zjh_hc161_seq;

    logic       Clk = 1'b0;
    logic       MR;
    logic       start;
    logic [3:0] preset;
    logic [7:0] passes;
`ifdef ZJH_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [3:0] q_in;
    logic       tc;
    logic       pe_n;
    logic [3:0] d_out;
    logic       cep;
    logic       cet;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] pass_cnt;
    logic [3:0] q_hc;
    logic       force_zero;

    int n_vec = 0;
    int n_mis = 0;

    always #5 Clk = ~Clk;

    assign q_in = force_zero ? 4'h0 : q_hc;

    zjh_hc161_seq #(.PASS_W(8)) dut (
        .Clk      (Clk),
        .MR       (MR),
        .start    (start),
        .preset   (preset),
        .passes   (passes),
`ifdef ZJH_SEQ_PAUSE_EN
        .pause    (pause),
`endif
        .q_in     (q_in),
        .tc_in    (tc),
        .pe_n     (pe_n),
        .d_out    (d_out),
        .cep      (cep),
        .cet      (cet),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pass_cnt (pass_cnt)
    );

    zjh_74HC161 u_hc161 (
        .Clk (Clk),
        .MR  (1'b1),
        .PE  (pe_n),
        .D   (d_out),
        .Cep (cep),
        .Cet (cet),
        .Q   (q_hc),
        .TC  (tc)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        MR = 1'b1; start = 1'b0; preset = 4'h0; passes = 8'd0; force_zero = 1'b0;
`ifdef ZJH_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        tick(); tick();
        n_vec++;
        if ({pe_n, d_out, cep, cet, busy, done, err, pass_cnt} !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_mis++;
            $display("FAIL reset_outputs: got pe_n=%b d=%h cep=%b cet=%b busy=%b done=%b err=%b pc=%0d, want 1 0 0 0 0 0 0 0",
                     pe_n, d_out, cep, cet, busy, done, err, pass_cnt);
        end
        MR = 1'b0;
        tick();
        $display("reset: outputs idle");
    endtask

    // preset=12 passes=3; a start pulse mid-run must be ignored
    task automatic test_basic();
        int done_cyc = -1;
        logic [3:0] exp_q;
        preset = 4'd12; passes = 8'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            start = 1'b0;
            if (cyc == 1) begin
                n_vec++;
                if (pe_n !== 1'b0 || busy !== 1'b1 || d_out !== 4'd12) begin
                    n_mis++;
                    $display("FAIL basic_load: got pe_n=%b busy=%b d=%0d, want 0 1 12", pe_n, busy, d_out);
                end
            end
            if (cyc == 6) begin
                start = 1'b1; preset = 4'd0; passes = 8'd1;
            end
            if (cyc == 7) begin
                start = 1'b0; preset = 4'd12; passes = 8'd3;
            end
            if (cyc >= 2 && cyc <= 14) begin
                exp_q = 4'(12 + ((cyc - 2) % 4));
                n_vec++;
                if (q_hc !== exp_q) begin
                    n_mis++;
                    $display("FAIL basic_q_seq: cyc %0d got Q=%0d, want %0d", cyc, q_hc, exp_q);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_vec++;
        if (done_cyc != 14) begin
            n_mis++;
            $display("FAIL basic_done_time: got cycle %0d, want 14", done_cyc);
        end
        n_vec++;
        if (pass_cnt !== 8'd3 || q_hc !== 4'd12 || err !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL basic_end_state: got pc=%0d Q=%0d err=%b busy=%b, want 3 12 0 0", pass_cnt, q_hc, err, busy);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_mis++;
            $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", done);
        end
        $display("basic: preset=12 passes=3 done at cycle %0d pass_cnt=%0d", done_cyc, pass_cnt);
    endtask

    task automatic test_zero_passes();
        preset = 4'd7; passes = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || pe_n !== 1'b1 || cep !== 1'b0 || busy !== 1'b0 || pass_cnt !== 8'd0) begin
            n_mis++;
            $display("FAIL zero_passes_done: got done=%b pe_n=%b cep=%b busy=%b pc=%0d, want 1 1 0 0 0",
                     done, pe_n, cep, busy, pass_cnt);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || pe_n !== 1'b1 || cep !== 1'b0) begin
            n_mis++;
            $display("FAIL zero_passes_after: got done=%b pe_n=%b cep=%b, want 0 1 0", done, pe_n, cep);
        end
        $display("zero_passes: done pulse without load");
    endtask

    task automatic test_preset15();
        int done_cyc = -1;
        preset = 4'd15; passes = 8'd4; start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            start = 1'b0;
            if (cyc >= 2 && cyc <= 5) begin
                n_vec++;
                if (pass_cnt !== 8'(cyc - 2) || tc !== 1'b1) begin
                    n_mis++;
                    $display("FAIL p15_pass_step: cyc %0d got pc=%0d tc=%b, want %0d 1", cyc, pass_cnt, tc, cyc - 2);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_vec++;
        if (done_cyc != 6 || pass_cnt !== 8'd4) begin
            n_mis++;
            $display("FAIL p15_done: got cycle %0d pc=%0d, want 6 4", done_cyc, pass_cnt);
        end
        tick();
        $display("preset15: done at cycle %0d pass_cnt=%0d", done_cyc, pass_cnt);
    endtask

    task automatic test_mid_reset();
        int  done_cyc = -1;
        bit  seen     = 1'b0;
        bit  stray    = 1'b0;
        preset = 4'd8; passes = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pass_cnt == 8'd1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_mis++;
            $display("FAIL midrst_first_pass: got pc=%0d after timeout, want 1", pass_cnt);
        end
        tick(); tick();
        MR = 1'b1;
        tick();
        MR = 1'b0;
        n_vec++;
        if ({pe_n, d_out, cep, cet, busy, done, err, pass_cnt} !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_mis++;
            $display("FAIL midrst_outputs: got pe_n=%b d=%h cep=%b cet=%b busy=%b done=%b err=%b pc=%0d, want 1 0 0 0 0 0 0 0",
                     pe_n, d_out, cep, cet, busy, done, err, pass_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        n_vec++;
        if (stray) begin
            n_mis++;
            $display("FAIL midrst_quiet: got done/busy activity after reset, want none");
        end
        preset = 4'd8; passes = 8'd1; start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_vec++;
        if (done_cyc != 10 || pass_cnt !== 8'd1 || q_hc !== 4'd8) begin
            n_mis++;
            $display("FAIL midrst_rerun: got cycle %0d pc=%0d Q=%0d, want 10 1 8", done_cyc, pass_cnt, q_hc);
        end
        tick();
        $display("mid_reset: rerun done at cycle %0d", done_cyc);
    endtask

    task automatic test_readback_err();
        int done_cyc = -1;
        force_zero = 1'b1;
        preset = 4'd5; passes = 8'd2; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            start = 1'b0;
            if (cyc == 2) begin
                n_vec++;
                if (err !== 1'b0) begin
                    n_mis++;
                    $display("FAIL rb_err_early: got err=%b in first COUNT cycle, want 0", err);
                end
            end
            if (cyc == 3) begin
                n_vec++;
                if (err !== 1'b1) begin
                    n_mis++;
                    $display("FAIL rb_err_set: got err=%b, want 1", err);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_vec++;
        if (done_cyc != 24 || err !== 1'b1 || pass_cnt !== 8'd2) begin
            n_mis++;
            $display("FAIL rb_err_done: got cycle %0d err=%b pc=%0d, want 24 1 2", done_cyc, err, pass_cnt);
        end
        force_zero = 1'b0;
        tick();
        n_vec++;
        if (err !== 1'b1) begin
            n_mis++;
            $display("FAIL rb_err_sticky: got err=%b in IDLE, want 1", err);
        end
        preset = 4'd5; passes = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_mis++;
            $display("FAIL rb_err_clear: got err=%b after start, want 0", err);
        end
        done_cyc = -1;
        for (int cyc = 2; cyc <= 30; cyc++) begin
            tick();
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_vec++;
        if (done_cyc != 13 || err !== 1'b0) begin
            n_mis++;
            $display("FAIL rb_clean_run: got cycle %0d err=%b, want 13 0", done_cyc, err);
        end
        tick();
        $display("readback_err: err set on stuck Q, cleared by next start");
    endtask

`ifdef ZJH_SEQ_PAUSE_EN
    task automatic test_pause();
        preset = 4'd14; passes = 8'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick();
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (q_hc !== 4'd15 || cep !== 1'b0 || pe_n !== 1'b1 || cet !== 1'b1 || pass_cnt !== 8'd0) begin
                n_mis++;
                $display("FAIL pause_hold: k=%0d got Q=%0d cep=%b pe_n=%b cet=%b pc=%0d, want 15 0 1 1 0",
                         k, q_hc, cep, pe_n, cet, pass_cnt);
            end
            tick();
        end
        pause = 1'b0;
        tick();
        n_vec++;
        if (q_hc !== 4'd14 || pass_cnt !== 8'd1) begin
            n_mis++;
            $display("FAIL pause_release: got Q=%0d pc=%0d, want 14 1", q_hc, pass_cnt);
        end
        tick();
        tick();
        n_vec++;
        if (done !== 1'b1 || pass_cnt !== 8'd2) begin
            n_mis++;
            $display("FAIL pause_done: got done=%b pc=%0d, want 1 2", done, pass_cnt);
        end
        tick();
        $display("pause: TC held through pause counted once");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_passes();
        test_preset15();
        test_mid_reset();
        test_readback_err();
`ifdef ZJH_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
